mano_bus_regs: RTL and testbench
================================

# mano_bus_regs

Register file and common-bus multiplexer of the Mano basic computer, sitting directly downstream of the bus-select encoder. It consumes the 3-bit select `s`, drives the 16-bit common bus from one of seven sources, and updates AR, PC, DR, AC, IR and TR on the rising clock edge under per-register load, increment and clear controls. Memory is external; this block presents address, write data and write strobe to it.

## Interface
- `DATA_W`, default 16: width of the bus and of DR, AC, IR, TR.
- `ADDR_W`, default 12: width of AR and PC.

- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `s` input 3: bus source select, from the bus-select encoder.
- `ar_ld`, `ar_inr`, `ar_clr` input 1 each: AR controls.
- `pc_ld`, `pc_inr`, `pc_clr` input 1 each: PC controls.
- `dr_ld`, `dr_inr`, `dr_clr` input 1 each: DR controls.
- `ac_ld`, `ac_inr`, `ac_clr` input 1 each: AC controls. AC loads from `alu_in`, never from the bus.
- `ir_ld` input 1: IR load. IR has no increment or clear.
- `tr_ld`, `tr_inr`, `tr_clr` input 1 each: TR controls.
- `alu_in` input DATA_W: ALU result, the AC load source.
- `mem_rdata` input DATA_W: memory read word, the bus source for `s`=111.
- `mem_write` input 1: memory write request.
- `bus` output DATA_W: common bus value.
- `mem_addr` output ADDR_W: equals AR.
- `mem_wdata` output DATA_W: equals `bus`.
- `mem_we` output 1: equals `mem_write`.
- `ar_q`, `pc_q` output ADDR_W; `dr_q`, `ac_q`, `ir_q`, `tr_q` output DATA_W: register contents.

## Operation
- Bus sources by `s`:
  - 000: all zeros.
  - 001: AR.
  - 010: PC.
  - 011: DR.
  - 100: AC.
  - 101: IR.
  - 110: TR.
  - 111: `mem_rdata`.
- Width rules:
  - 12-bit sources are zero-extended to DATA_W on the bus.
  - AR and PC load `bus[ADDR_W-1:0]`. Upper bus bits are ignored.
- Per-register priority when controls are asserted together: clr > ld > inr. Example: clr+ld gives 0. ld+inr gives the loaded value.
- Increment is modulo 2^width. PC 0xFFF+1 = 0x000. DR, AC and TR wrap from 0xFFFF to 0x0000.
- With no control asserted, a register holds its value.
- `bus`, `mem_addr`, `mem_wdata` and `mem_we` are purely combinational. They carry no register stage.
- Reset (asynchronous assert, any time including mid-transfer): AR, PC, DR, AC, IR and TR all become 0 immediately. `bus` becomes 0 unless `s` selects `mem_rdata`. Control inputs are ignored while `rst_n`=0. The first update happens on the first rising edge after release.

## Timing
- The bus reflects the *current* register contents, so a register read onto the bus and updated in the same cycle supplies its pre-edge value.
  - `s`=010 with `ar_ld` and `pc_inr` gives AR=old PC and PC=old PC+1.
  - `s`=011 with `dr_ld` is a legal self-load, leaving DR unchanged.
- Load and increment latency: 1 cycle. The new value is visible on `*_q` after the edge.
- Memory read to register: `s`=111 and `ir_ld` in cycle N gives IR=`mem_rdata` sampled at the end of cycle N. Memory is asynchronous-read from the block's point of view.
- Memory write: `mem_we`, `mem_addr` and `mem_wdata` are valid in the same cycle `mem_write` is high. The external memory commits on that cycle's edge.

## Structure
- Shared package `mano_pkg` holds:
  - The `s` encodings as named constants: `SEL_NONE`, `SEL_AR`, `SEL_PC`, `SEL_DR`, `SEL_AC`, `SEL_IR`, `SEL_TR`, `SEL_MEM`.
  - Default `DATA_W` and `ADDR_W`.
- Sub-module `mano_reg`:
  - Parameterized width.
  - Ports: `clk`, `rst_n`, `ld`, `inr`, `clr`, `d`, `q`.
  - Implements the clr > ld > inr priority.
  - Instantiated for AR, PC, DR, AC and TR. IR uses it with `inr` and `clr` tied low.
- The bus mux is one combinational case on `s` in the top level.

## Test plan
- Reset: preload all registers to non-zero values, pull `rst_n` low mid-cycle → every `*_q` is 0 before the next edge. With `s`=000, `bus`=0x0000.
- Fetch:
  - PC=0x0FF, `s`=010, `ar_ld`=1, `pc_inr`=1 → AR=0x0FF, PC=0x100.
  - Next cycle, `s`=111, `mem_rdata`=0x7800, `ir_ld`=1 → IR=0x7800.
- Wrap:
  - PC=0xFFF, `pc_inr` → PC=0x000.
  - AC=0xFFFF, `ac_inr` → AC=0x0000.
- Priority:
  - DR=0x1234, `s`=100 with AC=0xABCD, `dr_ld`+`dr_clr` → DR=0.
  - Then `dr_ld`+`dr_inr` → DR=0xABCD.
- Width: `s`=100 with AC=0xF123, `ar_ld` → AR=0x123. Then `s`=001 → `bus`=0x0123.
- Memory write: AR=0x040, TR=0x5555, `s`=110, `mem_write`=1 → `mem_addr`=0x040, `mem_wdata`=0x5555, `mem_we`=1 in the same cycle.

Source files
------------

// File: rtl/mano_pkg.sv
// rtl/mano_pkg.sv - shared constants for the Mano basic computer datapath
package mano_pkg;

  localparam int MANO_DATA_W = 16;
  localparam int MANO_ADDR_W = 12;

  // Common-bus source select codes
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_AR   = 3'b001;
  localparam logic [2:0] SEL_PC   = 3'b010;
  localparam logic [2:0] SEL_DR   = 3'b011;
  localparam logic [2:0] SEL_AC   = 3'b100;
  localparam logic [2:0] SEL_IR   = 3'b101;
  localparam logic [2:0] SEL_TR   = 3'b110;
  localparam logic [2:0] SEL_MEM  = 3'b111;

endpackage

// File: rtl/mano_reg.sv
// rtl/mano_reg.sv - register with clear, load and increment (clr > ld > inr)
module mano_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         inr,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (inr) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mano_bus_regs.sv
// rtl/mano_bus_regs.sv - Mano register file and common-bus multiplexer
module mano_bus_regs
  import mano_pkg::*;
#(
  parameter int DATA_W = MANO_DATA_W,
  parameter int ADDR_W = MANO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        s,
  input  logic              ar_ld,
  input  logic              ar_inr,
  input  logic              ar_clr,
  input  logic              pc_ld,
  input  logic              pc_inr,
  input  logic              pc_clr,
  input  logic              dr_ld,
  input  logic              dr_inr,
  input  logic              dr_clr,
  input  logic              ac_ld,
  input  logic              ac_inr,
  input  logic              ac_clr,
  input  logic              ir_ld,
  input  logic              tr_ld,
  input  logic              tr_inr,
  input  logic              tr_clr,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_write,
  output logic [DATA_W-1:0] bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] ar_q,
  output logic [ADDR_W-1:0] pc_q,
  output logic [DATA_W-1:0] dr_q,
  output logic [DATA_W-1:0] ac_q,
  output logic [DATA_W-1:0] ir_q,
  output logic [DATA_W-1:0] tr_q
);

  // Bus shows pre-edge register contents; address registers are zero-extended
  always_comb begin
    bus = '0;
    case (s)
      SEL_NONE: bus = '0;
      SEL_AR:   bus = DATA_W'(ar_q);
      SEL_PC:   bus = DATA_W'(pc_q);
      SEL_DR:   bus = dr_q;
      SEL_AC:   bus = ac_q;
      SEL_IR:   bus = ir_q;
      SEL_TR:   bus = tr_q;
      SEL_MEM:  bus = mem_rdata;
      default:  bus = '0;
    endcase
  end

  assign mem_addr  = ar_q;
  assign mem_wdata = bus;
  assign mem_we    = mem_write;

  mano_reg #(.W(ADDR_W)) u_ar (
    .clk(clk), .rst_n(rst_n), .ld(ar_ld), .inr(ar_inr), .clr(ar_clr),
    .d(bus[ADDR_W-1:0]), .q(ar_q)
  );

  mano_reg #(.W(ADDR_W)) u_pc (
    .clk(clk), .rst_n(rst_n), .ld(pc_ld), .inr(pc_inr), .clr(pc_clr),
    .d(bus[ADDR_W-1:0]), .q(pc_q)
  );

  mano_reg #(.W(DATA_W)) u_dr (
    .clk(clk), .rst_n(rst_n), .ld(dr_ld), .inr(dr_inr), .clr(dr_clr),
    .d(bus), .q(dr_q)
  );

  // AC takes the ALU result, never the bus
  mano_reg #(.W(DATA_W)) u_ac (
    .clk(clk), .rst_n(rst_n), .ld(ac_ld), .inr(ac_inr), .clr(ac_clr),
    .d(alu_in), .q(ac_q)
  );

  mano_reg #(.W(DATA_W)) u_ir (
    .clk(clk), .rst_n(rst_n), .ld(ir_ld), .inr(1'b0), .clr(1'b0),
    .d(bus), .q(ir_q)
  );

  mano_reg #(.W(DATA_W)) u_tr (
    .clk(clk), .rst_n(rst_n), .ld(tr_ld), .inr(tr_inr), .clr(tr_clr),
    .d(bus), .q(tr_q)
  );

endmodule

// File: tb/tb_mano_bus_regs.sv
// tb/tb_mano_bus_regs.sv - self-checking bench for mano_bus_regs
module tb_mano_bus_regs;

  // Control word: register i owns bits 3i (ld), 3i+1 (inr), 3i+2 (clr); bit 18 is mem_write
  localparam logic [18:0] AR_LD  = 19'd1 << 0;
  localparam logic [18:0] AR_INR = 19'd1 << 1;
  localparam logic [18:0] PC_LD  = 19'd1 << 3;
  localparam logic [18:0] PC_INR = 19'd1 << 4;
  localparam logic [18:0] PC_CLR = 19'd1 << 5;
  localparam logic [18:0] DR_LD  = 19'd1 << 6;
  localparam logic [18:0] DR_INR = 19'd1 << 7;
  localparam logic [18:0] DR_CLR = 19'd1 << 8;
  localparam logic [18:0] AC_LD  = 19'd1 << 9;
  localparam logic [18:0] AC_INR = 19'd1 << 10;
  localparam logic [18:0] AC_CLR = 19'd1 << 11;
  localparam logic [18:0] IR_LD  = 19'd1 << 12;
  localparam logic [18:0] TR_LD  = 19'd1 << 15;
  localparam logic [18:0] TR_INR = 19'd1 << 16;
  localparam logic [18:0] TR_CLR = 19'd1 << 17;
  localparam logic [18:0] MEM_WR = 19'd1 << 18;

  typedef struct {
    logic [2:0]  s;
    logic [15:0] mem;
    logic [15:0] alu;
    logic [18:0] c;
    logic [15:0] e_bus;
    logic [11:0] e_ar, e_pc;
    logic [15:0] e_dr, e_ac, e_ir, e_tr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  s;
  logic        ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr;
  logic        dr_ld, dr_inr, dr_clr, ac_ld, ac_inr, ac_clr;
  logic        ir_ld, tr_ld, tr_inr, tr_clr;
  logic [15:0] alu_in, mem_rdata;
  logic        mem_write;
  logic [15:0] bus, mem_wdata, dr_q, ac_q, ir_q, tr_q;
  logic [11:0] mem_addr, ar_q, pc_q;
  logic        mem_we;

  int n_vec = 0;
  int n_bad = 0;
  int unsigned m [6];   // reference contents: ar, pc, dr, ac, ir, tr
  vec_t tbl [21];

  mano_bus_regs dut (
    .clk(clk), .rst_n(rst_n), .s(s),
    .ar_ld(ar_ld), .ar_inr(ar_inr), .ar_clr(ar_clr),
    .pc_ld(pc_ld), .pc_inr(pc_inr), .pc_clr(pc_clr),
    .dr_ld(dr_ld), .dr_inr(dr_inr), .dr_clr(dr_clr),
    .ac_ld(ac_ld), .ac_inr(ac_inr), .ac_clr(ac_clr),
    .ir_ld(ir_ld), .tr_ld(tr_ld), .tr_inr(tr_inr), .tr_clr(tr_clr),
    .alu_in(alu_in), .mem_rdata(mem_rdata), .mem_write(mem_write),
    .bus(bus), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .ar_q(ar_q), .pc_q(pc_q), .dr_q(dr_q), .ac_q(ac_q), .ir_q(ir_q), .tr_q(tr_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] sv, input logic [15:0] mv, input logic [15:0] av,
                              input logic [18:0] cv, input logic [15:0] eb,
                              input logic [11:0] ear, input logic [11:0] epc,
                              input logic [15:0] edr, input logic [15:0] eac,
                              input logic [15:0] eir, input logic [15:0] etr);
    vec_t v;
    v.s = sv; v.mem = mv; v.alu = av; v.c = cv; v.e_bus = eb;
    v.e_ar = ear; v.e_pc = epc; v.e_dr = edr; v.e_ac = eac; v.e_ir = eir; v.e_tr = etr;
    return v;
  endfunction

  task automatic drive(input logic [2:0] sv, input logic [15:0] mv, input logic [15:0] av,
                       input logic [18:0] cv);
    s = sv; mem_rdata = mv; alu_in = av;
    {ar_clr, ar_inr, ar_ld} = cv[2:0];
    {pc_clr, pc_inr, pc_ld} = cv[5:3];
    {dr_clr, dr_inr, dr_ld} = cv[8:6];
    {ac_clr, ac_inr, ac_ld} = cv[11:9];
    ir_ld = cv[12];
    {tr_clr, tr_inr, tr_ld} = cv[17:15];
    mem_write = cv[18];
  endtask

  function automatic logic [15:0] model_bus(input logic [2:0] sv, input logic [15:0] mv);
    logic [15:0] src [8];
    src[0] = 16'h0000;
    for (int i = 0; i < 6; i++) src[i+1] = 16'(m[i]);
    src[7] = mv;
    return src[sv];
  endfunction

  task automatic model_step(input vec_t v);
    int unsigned nm [6];
    logic [15:0] b;
    b = model_bus(v.s, v.mem);
    for (int i = 0; i < 6; i++) begin
      bit ld, inr, clr;
      int unsigned mask, src;
      ld  = v.c[3*i];
      inr = (i == 4) ? 1'b0 : v.c[3*i+1];
      clr = (i == 4) ? 1'b0 : v.c[3*i+2];
      mask = (i < 2) ? 32'h0FFF : 32'hFFFF;
      src  = (i == 3) ? 32'(v.alu) : 32'(b);
      if (clr)      nm[i] = 0;
      else if (ld)  nm[i] = src & mask;
      else if (inr) nm[i] = (m[i] + 1) % (mask + 1);
      else          nm[i] = m[i];
    end
    m = nm;
  endtask

  // Called at posedge+1; drives, checks combinational outputs, then registers after the edge
  task automatic apply(input vec_t v, input bit from_table);
    logic [15:0] eb;
    drive(v.s, v.mem, v.alu, v.c);
    #2;
    eb = from_table ? v.e_bus : model_bus(v.s, v.mem);
    chk("bus", 32'(bus), 32'(eb));
    chk("mem_addr", 32'(mem_addr), m[0]);
    chk("mem_wdata", 32'(mem_wdata), 32'(eb));
    chk("mem_we", 32'(mem_we), 32'(v.c[18]));
    model_step(v);
    @(posedge clk);
    #1;
    if (from_table) begin
      chk("ar_q", 32'(ar_q), 32'(v.e_ar));
      chk("pc_q", 32'(pc_q), 32'(v.e_pc));
      chk("dr_q", 32'(dr_q), 32'(v.e_dr));
      chk("ac_q", 32'(ac_q), 32'(v.e_ac));
      chk("ir_q", 32'(ir_q), 32'(v.e_ir));
      chk("tr_q", 32'(tr_q), 32'(v.e_tr));
    end else begin
      chk("ar_q", 32'(ar_q), m[0]);
      chk("pc_q", 32'(pc_q), m[1]);
      chk("dr_q", 32'(dr_q), m[2]);
      chk("ac_q", 32'(ac_q), m[3]);
      chk("ir_q", 32'(ir_q), m[4]);
      chk("tr_q", 32'(tr_q), m[5]);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ar"}, 32'(ar_q), 0);
    chk({tag, "_pc"}, 32'(pc_q), 0);
    chk({tag, "_dr"}, 32'(dr_q), 0);
    chk({tag, "_ac"}, 32'(ac_q), 0);
    chk({tag, "_ir"}, 32'(ir_q), 0);
    chk({tag, "_tr"}, 32'(tr_q), 0);
  endtask

  initial begin
    vec_t v;
    //               s     mem       alu       ctl                      bus       ar      pc      dr        ac        ir        tr
    tbl[0]  = mk(3'd7, 16'h00FF, 16'h0000, PC_LD,                  16'h00FF, 12'h000, 12'h0FF, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[1]  = mk(3'd2, 16'h0000, 16'h0000, AR_LD | PC_INR,         16'h00FF, 12'h0FF, 12'h100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[2]  = mk(3'd7, 16'h7800, 16'h0000, IR_LD,                  16'h7800, 12'h0FF, 12'h100, 16'h0000, 16'h0000, 16'h7800, 16'h0000);
    tbl[3]  = mk(3'd7, 16'hFFFF, 16'h0000, PC_LD,                  16'hFFFF, 12'h0FF, 12'hFFF, 16'h0000, 16'h0000, 16'h7800, 16'h0000);
    tbl[4]  = mk(3'd0, 16'h1111, 16'h0000, PC_INR,                 16'h0000, 12'h0FF, 12'h000, 16'h0000, 16'h0000, 16'h7800, 16'h0000);
    tbl[5]  = mk(3'd0, 16'h0000, 16'hFFFF, AC_LD,                  16'h0000, 12'h0FF, 12'h000, 16'h0000, 16'hFFFF, 16'h7800, 16'h0000);
    tbl[6]  = mk(3'd0, 16'h0000, 16'h0000, AC_INR,                 16'h0000, 12'h0FF, 12'h000, 16'h0000, 16'h0000, 16'h7800, 16'h0000);
    tbl[7]  = mk(3'd7, 16'h1234, 16'h0000, DR_LD,                  16'h1234, 12'h0FF, 12'h000, 16'h1234, 16'h0000, 16'h7800, 16'h0000);
    tbl[8]  = mk(3'd0, 16'h0000, 16'hABCD, AC_LD,                  16'h0000, 12'h0FF, 12'h000, 16'h1234, 16'hABCD, 16'h7800, 16'h0000);
    tbl[9]  = mk(3'd4, 16'h0000, 16'h0000, DR_LD | DR_CLR,         16'hABCD, 12'h0FF, 12'h000, 16'h0000, 16'hABCD, 16'h7800, 16'h0000);
    tbl[10] = mk(3'd4, 16'h0000, 16'h0000, DR_LD | DR_INR,         16'hABCD, 12'h0FF, 12'h000, 16'hABCD, 16'hABCD, 16'h7800, 16'h0000);
    tbl[11] = mk(3'd3, 16'h0000, 16'h0000, DR_LD,                  16'hABCD, 12'h0FF, 12'h000, 16'hABCD, 16'hABCD, 16'h7800, 16'h0000);
    tbl[12] = mk(3'd0, 16'h0000, 16'hF123, AC_LD,                  16'h0000, 12'h0FF, 12'h000, 16'hABCD, 16'hF123, 16'h7800, 16'h0000);
    tbl[13] = mk(3'd4, 16'h0000, 16'h0000, AR_LD,                  16'hF123, 12'h123, 12'h000, 16'hABCD, 16'hF123, 16'h7800, 16'h0000);
    tbl[14] = mk(3'd1, 16'h0000, 16'h0000, 19'd0,                  16'h0123, 12'h123, 12'h000, 16'hABCD, 16'hF123, 16'h7800, 16'h0000);
    tbl[15] = mk(3'd7, 16'h0040, 16'h0000, AR_LD,                  16'h0040, 12'h040, 12'h000, 16'hABCD, 16'hF123, 16'h7800, 16'h0000);
    tbl[16] = mk(3'd7, 16'h5555, 16'h0000, TR_LD,                  16'h5555, 12'h040, 12'h000, 16'hABCD, 16'hF123, 16'h7800, 16'h5555);
    tbl[17] = mk(3'd6, 16'h0000, 16'h0000, MEM_WR,                 16'h5555, 12'h040, 12'h000, 16'hABCD, 16'hF123, 16'h7800, 16'h5555);
    tbl[18] = mk(3'd6, 16'h0000, 16'h0000, TR_CLR | TR_LD | TR_INR,16'h5555, 12'h040, 12'h000, 16'hABCD, 16'hF123, 16'h7800, 16'h0000);
    tbl[19] = mk(3'd0, 16'h0000, 16'h1111, AC_LD | AC_CLR,         16'h0000, 12'h040, 12'h000, 16'hABCD, 16'h0000, 16'h7800, 16'h0000);
    tbl[20] = mk(3'd0, 16'h0000, 16'h0000, AR_INR | IR_LD,         16'h0000, 12'h041, 12'h000, 16'hABCD, 16'h0000, 16'h0000, 16'h0000);

    rst_n = 1'b0;
    drive(3'd0, 16'h0000, 16'h0000, 19'd0);
    for (int i = 0; i < 6; i++) m[i] = 0;
    #1;
    chk_all_zero("por");
    chk("por_bus", 32'(bus), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) apply(tbl[i], 1'b1);

    for (int i = 0; i < 300; i++) begin
      v.s   = 3'($urandom_range(0, 7));
      v.mem = 16'($urandom);
      v.alu = 16'($urandom);
      v.c   = 19'($urandom & $urandom);
      if (i % 50 == 0) begin
        v.mem = 16'hFFFF;
        v.alu = 16'hFFFF;
      end
      apply(v, 1'b0);
    end

    // Preload every register non-zero, then assert reset between edges
    v = mk(3'd7, 16'hA5A5, 16'h3C3C, AR_LD | PC_LD | DR_LD | AC_LD | IR_LD | TR_LD,
           16'hA5A5, 12'h5A5, 12'h5A5, 16'hA5A5, 16'h3C3C, 16'hA5A5, 16'hA5A5);
    apply(v, 1'b1);
    #3;
    rst_n = 1'b0;
    drive(3'd0, 16'h1357, 16'hFFFF, 19'h3FFFF);
    #1;
    chk_all_zero("async_rst");
    chk("rst_bus_none", 32'(bus), 0);
    drive(3'd7, 16'h1357, 16'hFFFF, 19'h3FFFF);
    #1;
    chk("rst_bus_mem", 32'(bus), 32'h1357);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("held_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) m[i] = 0;
    apply(mk(3'd7, 16'h0ABC, 16'h0000, PC_LD | TR_LD, 16'h0, 12'h0, 12'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1'b0);
    chk("first_edge_pc", 32'(pc_q), 32'h0ABC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
